ram_xs3_p: RTL and testbench

RAM_XS3_P -- requirements
Module: ram_xs3_p

---
 rtl/ram_xs3_p_pkg.sv | 11 +
 rtl/ram_xs3_p_digit.sv | 13 +
 rtl/ram_xs3_p.sv | 141 ++++++++++++++
 tb/tb_ram_xs3_p.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_xs3_p_pkg.sv
// Shared constants and FSM encoding for the excess-3 word memory.
package ram_xs3_p_pkg;
  localparam int DIG_W = 4;
  localparam logic [3:0] XS3_OFF = 4'd3;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;
endpackage

// File: rtl/ram_xs3_p_digit.sv
// One BCD digit to excess-3: adds the offset and flags digits above 9.
module xs3_digit
  import ram_xs3_p_pkg::*;
(
  input  logic [DIG_W-1:0] bcd_i,
  output logic [DIG_W-1:0] xs3_o,
  output logic             bcd_ok_o
);
  always_comb begin
    xs3_o    = bcd_i + XS3_OFF;
    bcd_ok_o = (bcd_i <= BCD_MAX);
  end
endmodule

// File: rtl/ram_xs3_p.sv
// Single-port word memory storing BCD data as excess-3, with per-entry valid
// bits and a DEPTH-cycle clear sweep.
module ram_xs3_p
  import ram_xs3_p_pkg::*;
#(
  parameter int NDIG = 2,
  parameter int AW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we,
  input  logic [AW-1:0]           addr,
  input  logic [DIG_W*NDIG-1:0]   din,
  input  logic                    clr,
  output logic [DIG_W*NDIG-1:0]   dout_xs3,
  output logic [DIG_W*NDIG-1:0]   dout_bcd,
  output logic                    rd_valid,
  output logic                    rd_hit,
  output logic                    wr_err,
  output logic                    busy
);
  localparam int DW    = DIG_W * NDIG;
  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  state_e           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [DW-1:0]    dout_xs3_q, dout_xs3_d;
  logic [DW-1:0]    dout_bcd_q, dout_bcd_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_hit_q, rd_hit_d;
  logic             wr_err_q, wr_err_d;

  logic [DW-1:0]    wr_word;
  logic [NDIG-1:0]  dig_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_wa;
  logic [DW-1:0]    mem_wd;
  logic             rd_hit_w;
  logic [DW-1:0]    rd_word;
  logic [DW-1:0]    rd_bcd;

  for (genvar g = 0; g < NDIG; g++) begin : g_enc
    xs3_digit u_dig (
      .bcd_i    (din[g*DIG_W +: DIG_W]),
      .xs3_o    (wr_word[g*DIG_W +: DIG_W]),
      .bcd_ok_o (dig_ok[g])
    );
  end

  // Unwritten entries read as zero in both codings, so stale array data never leaks.
  always_comb begin
    rd_hit_w = vld_q[addr];
    rd_word  = rd_hit_w ? mem_q[addr] : '0;
    rd_bcd   = '0;
    if (rd_hit_w) begin
      for (int k = 0; k < NDIG; k++) begin
        rd_bcd[k*DIG_W +: DIG_W] = rd_word[k*DIG_W +: DIG_W] - XS3_OFF;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    vld_d      = vld_q;
    dout_xs3_d = dout_xs3_q;
    dout_bcd_d = dout_bcd_q;
    rd_valid_d = 1'b0;
    rd_hit_d   = 1'b0;
    wr_err_d   = 1'b0;
    mem_we     = 1'b0;
    mem_wa     = addr;
    mem_wd     = wr_word;
    case (state_q)
      ST_IDLE: begin
        // A clear request wins over an access presented in the same cycle.
        if (clr) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (cs && we) begin
          if (&dig_ok) begin
            mem_we      = 1'b1;
            vld_d[addr] = 1'b1;
          end else begin
            wr_err_d = 1'b1;
          end
        end else if (cs) begin
          rd_valid_d = 1'b1;
          rd_hit_d   = rd_hit_w;
          dout_xs3_d = rd_word;
          dout_bcd_d = rd_bcd;
        end
      end
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_wa       = ptr_q;
        mem_wd       = '0;
        vld_d[ptr_q] = 1'b0;
        ptr_d        = ptr_q + AW'(1);
        if (&ptr_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      vld_q      <= '0;
      dout_xs3_q <= '0;
      dout_bcd_q <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      vld_q      <= vld_d;
      dout_xs3_q <= dout_xs3_d;
      dout_bcd_q <= dout_bcd_d;
      rd_valid_q <= rd_valid_d;
      rd_hit_q   <= rd_hit_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_wa] <= mem_wd;
  end

  assign dout_xs3 = dout_xs3_q;
  assign dout_bcd = dout_bcd_q;
  assign rd_valid = rd_valid_q;
  assign rd_hit   = rd_hit_q;
  assign wr_err   = wr_err_q;
  assign busy     = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_ram_xs3_p.sv
// Randomized bench for ram_xs3_p against a word-level model of the memory.
module tb_ram_xs3_p;
  localparam int NDIG  = 2;
  localparam int AW    = 4;
  localparam int DW    = 4 * NDIG;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst, cs, we, clr;
  logic [AW-1:0] addr;
  logic [DW-1:0] din;
  logic [DW-1:0] dout_xs3, dout_bcd;
  logic          rd_valid, rd_hit, wr_err, busy;

  always #5 clk = ~clk;

  ram_xs3_p #(.NDIG(NDIG), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din), .clr(clr),
    .dout_xs3(dout_xs3), .dout_bcd(dout_bcd), .rd_valid(rd_valid),
    .rd_hit(rd_hit), .wr_err(wr_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: memory holds plain BCD words; the sweep is just a countdown.
  int            m_mem [DEPTH];
  bit            m_vld [DEPTH];
  int            m_busy_left = 0;
  logic [DW-1:0] e_xs3 = '0, e_bcd = '0;
  logic          e_rv = 1'b0, e_hit = 1'b0, e_err = 1'b0;

  function automatic bit m_is_bcd(input int v);
    for (int k = 0; k < NDIG; k++)
      if (((v >> (4 * k)) & 15) > 9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [DW-1:0] m_to_xs3(input int v);
    int r = 0;
    for (int k = 0; k < NDIG; k++)
      r += (((v >> (4 * k)) & 15) + 3) << (4 * k);
    return DW'(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_step();
    e_rv = 1'b0; e_hit = 1'b0; e_err = 1'b0;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      e_xs3 = '0; e_bcd = '0; m_busy_left = 0;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (clr) begin
      // Accesses are ignored for the whole sweep, so clearing every entry now is equivalent.
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      m_busy_left = DEPTH;
    end else if (cs && we) begin
      if (m_is_bcd(int'(din))) begin
        m_mem[int'(addr)] = int'(din);
        m_vld[int'(addr)] = 1'b1;
      end else begin
        e_err = 1'b1;
      end
    end else if (cs) begin
      e_rv  = 1'b1;
      e_hit = m_vld[int'(addr)];
      e_xs3 = e_hit ? m_to_xs3(m_mem[int'(addr)]) : '0;
      e_bcd = e_hit ? DW'(m_mem[int'(addr)]) : '0;
    end
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(e_rv));
    chk("rd_hit",   32'(rd_hit),   32'(e_hit));
    chk("wr_err",   32'(wr_err),   32'(e_err));
    chk("busy",     32'(busy),     32'(m_busy_left > 0));
    chk("dout_xs3", 32'(dout_xs3), 32'(e_xs3));
    chk("dout_bcd", 32'(dout_bcd), 32'(e_bcd));
  endtask

  task automatic idle();
    rst = 1'b0; cs = 1'b0; we = 1'b0; clr = 1'b0;
    tick();
  endtask

  task automatic wr(input int a, input int d);
    cs = 1'b1; we = 1'b1; addr = AW'(a); din = DW'(d);
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input int a);
    cs = 1'b1; we = 1'b0; addr = AW'(a);
    tick();
    cs = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_din();
    if ($urandom_range(0, 3) != 0)
      return DW'({4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))});
    return DW'($urandom_range(0, 255));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lit_a [4] = '{1, 3, 5, 7};
    int lit_x [4] = '{'h34, 'h36, 'h38, 'h3A};
    int lit_b [4] = '{'h01, 'h03, 'h05, 'h07};
    int busy_cnt;
    int hits;

    rst = 1'b1; cs = 1'b0; we = 1'b0; clr = 1'b0; addr = '0; din = '0;
    tick();
    tick();
    chk("lit_reset_dout", 32'(dout_xs3), 0);
    chk("lit_reset_busy", 32'(busy), 0);
    idle();

    for (int i = 0; i < 10; i++) wr(i, i);
    for (int j = 0; j < 4; j++) begin
      rd(lit_a[j]);
      chk($sformatf("lit_xs3_a%0d", lit_a[j]), 32'(dout_xs3), 32'(lit_x[j]));
      chk($sformatf("lit_bcd_a%0d", lit_a[j]), 32'(dout_bcd), 32'(lit_b[j]));
      chk($sformatf("lit_hit_a%0d", lit_a[j]), 32'(rd_hit), 1);
    end

    wr(2, 'h4B);
    chk("lit_wr_err_pulse", 32'(wr_err), 1);
    idle();
    chk("lit_wr_err_drop", 32'(wr_err), 0);
    rd(2);
    chk("lit_a2_kept_xs3", 32'(dout_xs3), 'h35);
    chk("lit_a2_kept_bcd", 32'(dout_bcd), 'h02);

    rd(15);
    chk("lit_a15_valid", 32'(rd_valid), 1);
    chk("lit_a15_hit", 32'(rd_hit), 0);
    chk("lit_a15_xs3", 32'(dout_xs3), 0);

    rd(7);
    for (int i = 0; i < 10; i++) begin
      cs = 1'b0; we = 1'(i & 1); addr = AW'($urandom_range(0, DEPTH - 1)); din = rand_din();
      tick();
    end
    chk("lit_hold_xs3", 32'(dout_xs3), 'h3A);
    chk("lit_hold_bcd", 32'(dout_bcd), 'h07);
    for (int i = 0; i < 10; i++) rd(i);

    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 149) == 0);
      clr  = ($urandom_range(0, 29) == 0);
      cs   = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1) == 1;
      addr = AW'($urandom_range(0, DEPTH - 1));
      din  = rand_din();
      tick();
    end
    rst = 1'b0; clr = 1'b0; cs = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) idle();

    for (int i = 0; i < DEPTH; i++) wr(i, 'h42);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      cs   = (i < 16);
      we   = $urandom_range(0, 1) == 1;
      addr = AW'($urandom_range(0, DEPTH - 1));
      din  = rand_din();
      clr  = (i == 3);
      tick();
      if (busy) busy_cnt++;
    end
    clr = 1'b0; cs = 1'b0;
    chk("lit_sweep_len", 32'(busy_cnt), 16);
    hits = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      hits += int'(rd_hit);
    end
    chk("lit_after_sweep_hits", 32'(hits), 0);

    for (int i = 0; i < DEPTH; i += 3) wr(i, 'h97);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 4; i++) idle();
    rst = 1'b1;
    tick();
    chk("lit_rst_abort_busy", 32'(busy), 0);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      hits += int'(rd_hit);
    end
    chk("lit_after_abort_hits", 32'(hits), 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
